// File: rtl/clock_phase_gen_pkg.sv
// Shared state encodings and helpers for the multi-channel clock phase generator.
package clkgen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A programmed half-period of zero behaves as one cycle.
  function automatic int unsigned norm_half(input int unsigned h);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/clock_phase_gen_if.sv
// Configuration write channel (valid/ready) for clock_phase_gen.
interface clock_phase_gen_if import clkgen_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_IDX_W = ch_idx_w(NUM_CH);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [CNT_W-1:0]    cfg_half;
  logic [CNT_W-1:0]    cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_half, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_half, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clock_phase_gen_channel.sv
// One divided-clock channel: phase/half-period counter plus toggle flop.
// Optional registered rise_pulse output when CLKGEN_PULSE_EN is defined.
module clkgen_channel import clkgen_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] half_i,
  input  logic [CNT_W-1:0] phase_i,
`ifdef CLKGEN_PULSE_EN
  output logic             rise_pulse_o,
`endif
  output logic             div_clk_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             at_zero;

  assign at_zero   = (cnt_q == '0);
  assign div_clk_o = div_q;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (clear_i) begin
      div_d = 1'b0;
    end else if (load_i) begin
      div_d = 1'b0;
      cnt_d = phase_i;
    end else if (enable_i) begin
      // Reload at zero rather than wrap, so the full counter range is a legal phase.
      if (at_zero) begin
        div_d = ~div_q;
        cnt_d = CNT_W'(norm_half(32'(half_i)) - 1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

`ifdef CLKGEN_PULSE_EN
  logic rise_q, rise_d;

  assign rise_d       = !clear_i && !load_i && enable_i && at_zero && !div_q;
  assign rise_pulse_o = rise_q;

  always_ff @(posedge clk) begin
    if (rst) rise_q <= 1'b0;
    else     rise_q <= rise_d;
  end
`endif

endmodule

// File: rtl/clock_phase_gen.sv
// Multi-channel clock divider with per-channel half-period/phase and global re-alignment on config change.
// Optional per-channel rise_pulse outputs are enabled by defining CLKGEN_PULSE_EN.
module clock_phase_gen import clkgen_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_i,
  clock_phase_gen_if.slave  cfg,
`ifdef CLKGEN_PULSE_EN
  output logic [NUM_CH-1:0] rise_pulse_o,
`endif
  output logic [NUM_CH-1:0] div_clk_o,
  output logic              active_o,
  output logic              sync_pulse_o
);

  logic [1:0]       state_q, state_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] sh_half_q  [NUM_CH];
  logic [CNT_W-1:0] sh_phase_q [NUM_CH];
  logic [CNT_W-1:0] act_half_q [NUM_CH];
  logic             accept, ch_ok;
  logic             ch_load, ch_enable, ch_clear;

  assign cfg.cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign ch_ok         = 32'(cfg.cfg_ch) < NUM_CH;
  assign active_o      = (state_q == ST_RUN);
  assign sync_pulse_o  = (state_q == ST_ALIGN);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE:   if (run_i) state_d = ST_ALIGN;
      ST_ALIGN: begin
        pending_d = 1'b0;
        state_d   = run_i ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (accept) pending_d = 1'b1;
        // Leave on the accepting edge so the re-alignment starts one cycle after the write.
        if (!run_i)                    state_d = ST_IDLE;
        else if (pending_q || accept)  state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = run_i ? ST_ALIGN : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Channels only count while staying in RUN; leaving RUN forces every output low on that edge.
  assign ch_load   = (state_q == ST_ALIGN);
  assign ch_enable = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign ch_clear  = !ch_load && !ch_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_half_q[i]  <= CNT_W'(DEFAULT_HALF);
        sh_phase_q[i] <= '0;
        act_half_q[i] <= CNT_W'(DEFAULT_HALF);
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (accept && ch_ok) begin
        sh_half_q[cfg.cfg_ch]  <= cfg.cfg_half;
        sh_phase_q[cfg.cfg_ch] <= cfg.cfg_phase;
      end
      if (state_q == ST_ALIGN) begin
        for (int i = 0; i < NUM_CH; i++) act_half_q[i] <= sh_half_q[i];
      end
    end
  end

  // Phase is consumed only at the ALIGN load, where it comes straight from the shadow copy.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkgen_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clock),
      .rst          (reset),
      .load_i       (ch_load),
      .enable_i     (ch_enable),
      .clear_i      (ch_clear),
      .half_i       (act_half_q[g]),
      .phase_i      (sh_phase_q[g]),
`ifdef CLKGEN_PULSE_EN
      .rise_pulse_o (rise_pulse_o[g]),
`endif
      .div_clk_o    (div_clk_o[g])
    );
  end

endmodule
